// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_serial_adder_pkg                                      |
// | Description : Shared definitions for the nibble-serial adder: slice width, |
// |               FSM state encoding and a nibble-count helper.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nibble_serial_adder_pkg;

   // Width of the ripple slice reused once per clock.
   localparam int SLICE_W = 4;

   // Controller states; encoding 2'd3 is unused and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of slice passes needed for a given operand width.
   function automatic int nib_count(input int width);
      return width / SLICE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_adder_slice                                           |
// | Description : Combinational 4-bit ripple adder built from four full-adder  |
// |               cells.                                                       |
// | Ports       : a, b  - 4-bit addends                                        |
// |               cin   - carry in                                             |
// |               s     - 4-bit sum                                            |
// |               cout  - carry out of bit 3                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nibble_adder_slice
   import nibble_serial_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] s,
   output logic               cout
);

   logic [SLICE_W:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout = w_c[SLICE_W];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_serial_adder                                          |
// | Description : Multi-cycle add/subtract controller. One 4-bit ripple slice  |
// |               is sequenced over WIDTH/4 nibbles, LSB first, one nibble per |
// |               clock, with the carry held in a register between nibbles.    |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               in_valid/in_ready   - request handshake (ready only in IDLE) |
// |               a, b, sub           - operands and op select, taken on accept|
// |               out_valid/out_ready - result handshake (valid only in DONE)  |
// |               sum, cout, ovf      - result, final carry, signed overflow   |
// |               busy                - operation in progress or result held   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NIB = nib_count(WIDTH);
   localparam int CW  = $clog2(NIB);
   localparam logic [CW-1:0] c_last = CW'(NIB - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;        // already inverted for subtraction
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_idx;
   logic             r_cout;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;

   logic [SLICE_W-1:0] w_s;
   logic               w_c;

   nibble_adder_slice u_slice (
      .a    (r_a[r_idx*SLICE_W +: SLICE_W]),
      .b    (r_b[r_idx*SLICE_W +: SLICE_W]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_idx       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction is A + ~B + 1: invert B here and seed carry.
                  r_a        <= a;
                  r_b        <= b ^ {WIDTH{sub}};
                  r_carry    <= sub;
                  r_idx      <= '0;
                  r_state    <= RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            RUN: begin
               r_sum[r_idx*SLICE_W +: SLICE_W] <= w_s;
               r_carry <= w_c;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == c_last) begin
                  // Flags use the MSB of the slice output being written now.
                  r_cout      <= w_c;
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 (w_s[SLICE_W-1] != r_a[WIDTH-1]);
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               // No accept here: the new request is taken from IDLE next cycle.
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nibble_serial_adder                                       |
// | Description : Self-checking bench for nibble_serial_adder (WIDTH=16):      |
// |               directed cases, handshake hold, mid-run reset and random     |
// |               back-to-back operations against an arithmetic model.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain unsigned/signed integer arithmetic. Returns {ovf, cout, sum}.
   function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic s);
      int ua, ub, sa, sb, ur, sr;
      logic c, o;
      ua = int'(x);
      ub = int'(y);
      sa = int'($signed(x));
      sb = int'($signed(y));
      if (s) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         sr = sa + sb;
         c  = (ur > 65535);
      end
      o = (sr > 32767) || (sr < -32768);
      return {o, c, ur[WIDTH-1:0]};
   endfunction

   // Present a request, wait for accept and for the result; check latency and result.
   task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic ts, input logic [WIDTH+1:0] exp, input string tag);
      int n;
      a = ta; b = tb; sub = ts; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin step(); n++; end
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      // Operands changing after accept must not disturb the running operation.
      a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      chk({tag, " latency"}, 32'(n), 32'(NIB));
      chk({tag, " sum"},  32'(sum),  32'(exp[WIDTH-1:0]));
      chk({tag, " cout"}, 32'(cout), 32'(exp[WIDTH]));
      chk({tag, " ovf"},  32'(ovf),  32'(exp[WIDTH+1]));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " in_ready_done"}, 32'(in_ready), 32'd0);
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " out_valid_low"}, 32'(out_valid), 32'd0);
      chk({tag, " idle_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [WIDTH-1:0] hs;
      logic [WIDTH+1:0] ex;
      logic [WIDTH-1:0] ra, rb;
      logic             rs;
      int               n, last_acc;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      repeat (3) step();
      chk("rst in_ready",  32'(in_ready),  32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy",      32'(busy),      32'd0);
      chk("rst sum",       32'(sum),       32'd0);
      chk("rst cout",      32'(cout),      32'd0);
      chk("rst ovf",       32'(ovf),       32'd0);
      rst = 1'b0;
      step();

      // Directed cases with values fixed by hand.
      start_op(16'h1234, 16'h0FCD, 1'b0, {1'b0, 1'b0, 16'h2201}, "add1");
      finish_op("add1");
      start_op(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000}, "addwrap");
      finish_op("addwrap");
      start_op(16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000}, "addovf");
      finish_op("addovf");
      start_op(16'h0005, 16'h0007, 1'b1, {1'b0, 1'b0, 16'hFFFE}, "subneg");
      finish_op("subneg");
      start_op(16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF}, "subovf");

      // Hold the result for 5 cycles while a new request is waiting.
      hs = sum;
      a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold out_valid", 32'(out_valid), 32'd1);
         chk("hold sum",       32'(sum),       32'(hs));
         chk("hold cout",      32'(cout),      32'd1);
         chk("hold ovf",       32'(ovf),       32'd1);
         chk("hold in_ready",  32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("release busy",     32'(busy),     32'd0);
      chk("release in_ready", 32'(in_ready), 32'd1);
      chk("release sum_kept", 32'(sum),      32'(hs));
      start_op(16'h1111, 16'h2222, 1'b0, {1'b0, 1'b0, 16'h3333}, "after_hold");
      finish_op("after_hold");

      // Reset while the third nibble would be written.
      a = 16'hABCD; b = 16'h1357; sub = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("abort busy_run", 32'(busy), 32'd1);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort in_ready",  32'(in_ready),  32'd1);
      chk("abort out_valid", 32'(out_valid), 32'd0);
      chk("abort busy",      32'(busy),      32'd0);
      chk("abort sum",       32'(sum),       32'd0);
      chk("abort cout",      32'(cout),      32'd0);
      chk("abort ovf",       32'(ovf),       32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("abort no_valid", 32'(out_valid), 32'd0);
      end
      start_op(16'hABCD, 16'h1357, 1'b0, ref_op(16'hABCD, 16'h1357, 1'b0), "fresh");
      finish_op("fresh");

      // Back-to-back random traffic: in_valid and out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
      last_acc = 0;
      for (int i = 0; i < 1000; i++) begin
         n = 0;
         while (!in_ready && n < 20) begin step(); n++; end
         chk("b2b in_ready", 32'(in_ready), 32'd1);
         if (i > 0) chk("b2b period", 32'(cyc - last_acc), 32'(NIB + 2));
         last_acc = cyc;
         ra = a; rb = b; rs = sub;
         step();
         ex = ref_op(ra, rb, rs);
         a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
         n = 0;
         while (!out_valid && n < 20) begin step(); n++; end
         chk("b2b latency", 32'(n), 32'(NIB));
         chk("b2b sum",  32'(sum),  32'(ex[WIDTH-1:0]));
         chk("b2b cout", 32'(cout), 32'(ex[WIDTH]));
         chk("b2b ovf",  32'(ovf),  32'(ex[WIDTH+1]));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
